// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file with NRP combinational read ports, one write port
//   and a per-register busy scoreboard. Decode reserves a destination on
//   issue, writeback clears it, and the per-port busy flags feed the stall
//   logic with RAW/WAW hazard information. Register 0 is hardwired to zero
//   and is never busy.
//
// Parameters
//   XLEN    data width of each register
//   NREGS   number of architectural registers (power of two, >= 2)
//   AW      address width, equal to $clog2(NREGS)
//   NRP     number of read ports (1..4)
//   BYPASS  1: same-cycle write data/busy-clear forwarded to the read ports
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   rd_addr    read addresses, port p = [p*AW +: AW]
//   rd_data    read data, port p = [p*XLEN +: XLEN]
//   rd_busy    per-port: addressed register has a pending write
//   wr_en      writeback strobe
//   wr_addr    writeback destination
//   wr_data    writeback data
//   iss_valid  request to reserve iss_addr as a pending destination
//   iss_addr   destination being reserved
//   iss_ready  reservation can be accepted this cycle
//   flush      drop all outstanding reservations
//   pend_cnt   registered count of busy registers
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    // Element 0 is reset to zero and never written, so it always reads 0.
    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      pend_cnt_reg;
    logic [AW:0]      pend_cnt_next;
    logic             wr_fire;
    logic             iss_accept;

    assign wr_fire = wr_en & (wr_addr != '0);

    // A write landing on the reserved register in this same cycle frees the
    // slot, so a back-to-back reissue does not have to stall.
    assign iss_ready  = (iss_addr == '0) | ~busy_reg[iss_addr] |
                        (wr_en & (wr_addr == iss_addr));
    assign iss_accept = iss_valid & iss_ready & ~flush;

    // Scoreboard next state: flush > issue > writeback > hold.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic bit_next;
                always_comb begin
                    bit_next = busy_reg[gi];
                    if (flush) begin
                        bit_next = 1'b0;
                    end else if (iss_accept && (iss_addr == AW'(gi))) begin
                        bit_next = 1'b1;
                    end else if (wr_en && (wr_addr == AW'(gi))) begin
                        bit_next = 1'b0;
                    end
                end
                assign busy_next[gi] = bit_next;
            end
        end
    endgenerate

    always_comb begin
        pend_cnt_next = '0;
        for (int r = 0; r < NREGS; r++) begin
            pend_cnt_next = pend_cnt_next + (AW+1)'(busy_next[r]);
        end
    end

    // Read ports. Address 0 needs no special case: its storage and busy bit
    // are permanently zero, and wr_fire excludes it from forwarding.
    generate
        for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          hit;
            assign addr = rd_addr[gi*AW +: AW];
            assign hit  = (BYPASS != 0) && wr_fire && (wr_addr == addr);
            assign rd_data[gi*XLEN +: XLEN] = hit ? wr_data : regs_reg[addr];
            assign rd_busy[gi] = busy_reg[addr] & ~hit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
            busy_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            // Flush does not gate the write port.
            if (wr_fire) begin
                regs_reg[wr_addr] <= wr_data;
            end
            busy_reg     <= busy_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign pend_cnt = pend_cnt_reg;

endmodule
